maze_move_controller: RTL and testbench

Sequencer for the maze game datapath. It takes debounced button pulses and a move-rate tick. It arbitrates competing direction requests, checks each candidate step against the maze wall bitmap, and holds the authoritative player cell index. The renderer and the red-square mover consume that index. It also runs the game state machine (idle, play, paused, won) and counts moves.

---
 rtl/maze_pkg.sv | 23 ++
 rtl/maze_step_check.sv | 48 ++++
 rtl/maze_move_controller.sv | 163 ++++++++++++++++
 tb/tb_maze_move_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared encodings and default geometry for the maze game sequencer.
package maze_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StPlay   = 2'b01,
        StPaused = 2'b10,
        StWon    = 2'b11
    } game_state_e;

    typedef enum logic [2:0] {
        DirNone  = 3'd0,
        DirUp    = 3'd1,
        DirDown  = 3'd2,
        DirLeft  = 3'd3,
        DirRight = 3'd4
    } dir_e;

    localparam int unsigned DefCols     = 18;
    localparam int unsigned DefRows     = 11;
    localparam int unsigned DefStartPos = 19;

endpackage

// File: rtl/maze_step_check.sv
// Combinational step check: computes the target cell for a direction and whether
// the step stays inside the grid and lands on an open cell.
module maze_step_check
    import maze_pkg::*;
#(
    parameter int unsigned COLS = DefCols,
    parameter int unsigned ROWS = DefRows
) (
    input  logic [7:0]           pos_i,
    input  logic [2:0]           dir_i,
    input  logic [COLS*ROWS-1:0] maze_state_i,
    output logic [7:0]           target_o,
    output logic                 legal_o
);

    int unsigned col;
    int unsigned row;
    logic        in_bounds;

    always_comb begin
        col       = {24'd0, pos_i} % COLS;
        row       = {24'd0, pos_i} / COLS;
        target_o  = pos_i;
        in_bounds = 1'b0;
        case (dir_e'(dir_i))
            DirUp: begin
                in_bounds = (row != 0);
                target_o  = pos_i - 8'(COLS);
            end
            DirDown: begin
                in_bounds = (row != ROWS - 1);
                target_o  = pos_i + 8'(COLS);
            end
            DirLeft: begin
                in_bounds = (col != 0);
                target_o  = pos_i - 8'd1;
            end
            DirRight: begin
                in_bounds = (col != COLS - 1);
                target_o  = pos_i + 8'd1;
            end
            default: ;
        endcase
        // Out-of-grid targets are never indexed into the bitmap as legal.
        legal_o = in_bounds && (row < ROWS) && maze_state_i[target_o];
    end

endmodule

// File: rtl/maze_move_controller.sv
// Maze game sequencer: button edge latches, fixed-priority arbiter, game FSM and move counter.
// Optional MAZE_MOVE_LIMIT_EN ends the game when the move budget runs out.
module maze_move_controller
    import maze_pkg::*;
#(
    parameter int unsigned COLS      = DefCols,
    parameter int unsigned ROWS      = DefRows,
    parameter int unsigned START_POS = DefStartPos,
    parameter int unsigned MAX_MOVES = 500
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 tick,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_ctrl,
    input  logic                 pause,
    input  logic [COLS*ROWS-1:0] maze_state,
    input  logic [7:0]           goal_pos,
    output logic [7:0]           pos,
    output logic [9:0]           moves,
    output logic [1:0]           game_state,
    output logic                 blocked,
    output logic                 won
);

    game_state_e state_q, state_d;
    logic [7:0]  pos_q, pos_d;
    logic [9:0]  moves_q, moves_d;
    logic        blocked_q, blocked_d;
    logic [3:0]  pending_q, pending_d;  // {up, down, left, right}
    logic [3:0]  btn_prev_q, btn_prev_d;
    logic        ctrl_prev_q, ctrl_prev_d;

    logic [3:0]  dir_edge;
    logic [3:0]  req;
    logic        ctrl_edge;
    dir_e        winner;
    logic [7:0]  target;
    logic        legal;
    logic [9:0]  moves_inc;

    assign btn_prev_d  = {btn_up, btn_down, btn_left, btn_right};
    assign ctrl_prev_d = btn_ctrl;
    assign dir_edge    = btn_prev_d & ~btn_prev_q;
    assign ctrl_edge   = btn_ctrl & ~ctrl_prev_q;
    // An edge arriving on the tick cycle itself still competes for that tick.
    assign req         = pending_q | dir_edge;
    assign moves_inc   = (moves_q == 10'h3FF) ? moves_q : moves_q + 10'd1;

    always_comb begin
        winner = DirNone;
        if (req[3]) begin
            winner = DirUp;
        end else if (req[2]) begin
            winner = DirDown;
        end else if (req[1]) begin
            winner = DirLeft;
        end else if (req[0]) begin
            winner = DirRight;
        end
    end

    maze_step_check #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_step_check (
        .pos_i       (pos_q),
        .dir_i       (winner),
        .maze_state_i(maze_state),
        .target_o    (target),
        .legal_o     (legal)
    );

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        moves_d   = moves_q;
        blocked_d = 1'b0;
        pending_d = tick ? 4'b0000 : (pending_q | dir_edge);
        unique case (state_q)
            StIdle: begin
                if (ctrl_edge) begin
                    state_d = StPlay;
                    pos_d   = 8'(START_POS);
                    moves_d = 10'd0;
                end
            end
            StPlay: begin
                if (ctrl_edge) begin
                    state_d = StIdle;
                end else if (pause) begin
                    state_d = StPaused;
                end else if (tick && (winner != DirNone)) begin
                    if (legal) begin
                        pos_d   = target;
                        moves_d = moves_inc;
                        if (target == goal_pos) begin
                            state_d = StWon;
                        end
`ifdef MAZE_MOVE_LIMIT_EN
                        else if (moves_inc == 10'(MAX_MOVES)) begin
                            state_d   = StIdle;
                            pos_d     = 8'(START_POS);
                            blocked_d = 1'b1;
                        end
`endif
                    end else begin
                        blocked_d = 1'b1;
                    end
                end
            end
            StPaused: begin
                if (!pause) begin
                    state_d = StPlay;
                end
            end
            StWon: begin
                if (ctrl_edge) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            pending_d = 4'b0000;
        end
    end

`ifndef MAZE_MOVE_LIMIT_EN
    logic unused_max_moves;
    assign unused_max_moves = ^MAX_MOVES;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            pos_q       <= 8'(START_POS);
            moves_q     <= 10'd0;
            blocked_q   <= 1'b0;
            pending_q   <= 4'b0000;
            btn_prev_q  <= 4'b0000;
            ctrl_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            moves_q     <= moves_d;
            blocked_q   <= blocked_d;
            pending_q   <= pending_d;
            btn_prev_q  <= btn_prev_d;
            ctrl_prev_q <= ctrl_prev_d;
        end
    end

    assign pos        = pos_q;
    assign moves      = moves_q;
    assign game_state = state_q;
    assign blocked    = blocked_q;
    assign won        = (state_q == StWon);

endmodule

// File: tb/tb_maze_move_controller.sv
// Directed self-checking bench for maze_move_controller on the default 18x11 grid.
module tb_maze_move_controller;

    localparam int unsigned Cols  = 18;
    localparam int unsigned Rows  = 11;
    localparam int unsigned Cells = Cols * Rows;

    logic             CLK;
    logic             RESET;
    logic             tick;
    logic             btn_up, btn_down, btn_left, btn_right, btn_ctrl;
    logic             pause;
    logic [Cells-1:0] maze_state;
    logic [7:0]       goal_pos;
    logic [7:0]       pos;
    logic [9:0]       moves;
    logic [1:0]       game_state;
    logic             blocked;
    logic             won;

    int errors = 0;
    int checks = 0;

    maze_move_controller #(
        .COLS     (Cols),
        .ROWS     (Rows),
        .START_POS(19),
        .MAX_MOVES(500)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .tick      (tick),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_ctrl  (btn_ctrl),
        .pause     (pause),
        .maze_state(maze_state),
        .goal_pos  (goal_pos),
        .pos       (pos),
        .moves     (moves),
        .game_state(game_state),
        .blocked   (blocked),
        .won       (won)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 0 up, 1 down, 2 left, 3 right, 4 ctrl; one-cycle press, returns at negedge after the edge
    task automatic press(input int d);
        @(negedge CLK);
        case (d)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            2: btn_left = 1'b1;
            3: btn_right = 1'b1;
            default: btn_ctrl = 1'b1;
        endcase
        @(negedge CLK);
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_ctrl = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge CLK);
        tick = 1'b1;
        @(negedge CLK);
        tick = 1'b0;
    endtask

    task automatic move(input int d);
        press(d);
        do_tick();
    endtask

    initial begin
        RESET = 1'b0; tick = 1'b0; pause = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_ctrl = 1'b0;
        maze_state = '0;
        maze_state[19] = 1'b1; maze_state[20] = 1'b1; maze_state[35] = 1'b1;
        maze_state[36] = 1'b1; maze_state[37] = 1'b1; maze_state[54] = 1'b1;
        goal_pos = 8'd100;
        #13;
        check("rst_pos", int'(pos), 19);
        check("rst_moves", int'(moves), 0);
        check("rst_state", int'(game_state), 0);
        check("rst_blocked", int'(blocked), 0);
        check("rst_won", int'(won), 0);
        @(negedge CLK);
        RESET = 1'b1;

        press(4);
        check("start_state", int'(game_state), 1);
        check("start_pos", int'(pos), 19);
        check("start_moves", int'(moves), 0);

        move(3);
        check("right_pos", int'(pos), 20);
        check("right_moves", int'(moves), 1);
        check("right_blocked", int'(blocked), 0);
        move(2);
        check("left_back_pos", int'(pos), 19);
        check("left_back_moves", int'(moves), 2);

        move(0);
        check("wall_pos", int'(pos), 19);
        check("wall_blocked", int'(blocked), 1);
        @(negedge CLK);
        check("wall_blocked_drop", int'(blocked), 0);
        check("wall_moves", int'(moves), 2);

        press(4);
        check("abort_state", int'(game_state), 0);
        maze_state[1] = 1'b1;
        press(4);
        check("restart_moves", int'(moves), 0);
        press(0);
        press(3);
        do_tick();
        check("prio_pos", int'(pos), 1);
        check("prio_moves", int'(moves), 1);
        do_tick();
        check("idle_tick_pos", int'(pos), 1);
        check("idle_tick_moves", int'(moves), 1);

        move(1);
        move(1);
        move(2);
        check("path_pos", int'(pos), 36);
        check("path_moves", int'(moves), 4);
        move(2);
        check("nowrap_pos", int'(pos), 36);
        check("nowrap_blocked", int'(blocked), 1);

        press(1);
        @(negedge CLK);
        pause = 1'b1;
        tick = 1'b1;
        @(negedge CLK);
        tick = 1'b0;
        check("pause_state", int'(game_state), 2);
        check("pause_pos", int'(pos), 36);
        move(1);
        check("paused_tick_pos", int'(pos), 36);
        check("paused_tick_state", int'(game_state), 2);
        @(negedge CLK);
        pause = 1'b0;
        @(negedge CLK);
        check("resume_state", int'(game_state), 1);
        do_tick();
        check("resume_tick_pos", int'(pos), 36);

        press(4);
        goal_pos = 8'd20;
        press(4);
        check("win_start_pos", int'(pos), 19);
        move(3);
        check("win_pos", int'(pos), 20);
        check("win_state", int'(game_state), 3);
        check("win_won", int'(won), 1);
        check("win_moves", int'(moves), 1);
        move(2);
        check("won_frozen_pos", int'(pos), 20);
        press(4);
        check("won_exit_state", int'(game_state), 0);
        check("won_exit_won", int'(won), 0);

        goal_pos = 8'd19;
        press(4);
        check("goal_at_start_state", int'(game_state), 1);
        press(3);
        @(negedge CLK);
        btn_ctrl = 1'b1;
        tick = 1'b1;
        @(negedge CLK);
        btn_ctrl = 1'b0;
        tick = 1'b0;
        check("ctrl_tick_state", int'(game_state), 0);
        check("ctrl_tick_pos", int'(pos), 19);
        check("ctrl_tick_moves", int'(moves), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
